decode_stage: RTL and testbench
===============================

# decode_stage

Decode stage of the pipelined ARM core, directly downstream of the fetch stage. Takes the decode-stage instruction word and PC+4 from fetch, reads the 15-entry general register file (R15 synthesised as PC+8), extends the immediate field, accepts register write-back from the W stage, and registers all operands into the Decode→Execute pipeline register under stall/flush control from the hazard unit.

## Interface
Parameters:
- none (all widths fixed at 32-bit data, 4-bit register index)

Ports:
- clock  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- instrD  in  32  instruction word from the Fetch→Decode register
- pcPlus4D  in  32  PC+4 of the instruction in D (from fetch)
- regSrcD  in  2  control: [0]=1 selects R15 as RA1, [1]=1 selects Rd as RA2
- immSrcD  in  2  control: immediate extension format
- regWriteW  in  1  write-back enable from W stage
- wa3W  in  4  write-back register index
- resultW  in  32  write-back data
- pipeEnable  in  1  1 = D→E register loads; 0 = holds (stall)
- flushE  in  1  1 = D→E register clears on next edge
- rd1E  out  32  registered operand 1
- rd2E  out  32  registered operand 2
- extImmE  out  32  registered extended immediate
- wa3E  out  4  registered destination index (instrD[15:12])
- ra1E  out  4  registered source index 1 (for hazard/forwarding)
- ra2E  out  4  registered source index 2
- validE  out  1  1 = E holds a real (non-bubble) instruction

## Operation
- RA1 = regSrcD[0] ? 4'hF : instrD[19:16]; RA2 = regSrcD[1] ? instrD[15:12] : instrD[3:0].
- Read of index 15 returns pcPlus4D + 32'd4 (PC+8); indices 0–14 return register file contents.
- Register file: 15 × 32-bit, R0–R14. Write when regWriteW=1 at rising edge; write to index 15 ignored (PC redirection belongs to fetch via pcSrcW).
- Immediate extension: 00 → zero-extend instrD[7:0]; 01 → zero-extend instrD[11:0]; 10 → sign-extend instrD[23:0] then shift left 2 (branch offset); 11 → 32'h0.
- D→E register: flushE=1 → all outputs cleared to 0 (validE=0) regardless of pipeEnable; else pipeEnable=1 → load; else hold.
- validE loads 1 on a normal load; 0 after reset or flush.
- Write-back proceeds independently of pipeEnable/flushE.

## Timing
- Reads combinational within the D cycle; operands appear on *E outputs one rising edge later (latency 1).
- Write-back visible to a read in the cycle after the write edge.
- Same-cycle write and read of same index (0–14): governed by Configuration.
- Reset (async, any time, including mid-stall): all 15 registers = 0, all outputs = 0, validE = 0; held until rst deasserts; first load at first rising edge with rst=0.
- Simultaneous flushE and pipeEnable: flush wins.
- Arithmetic on pcPlus4D+4 wraps modulo 2^32.

## Configuration
- DECODE_WB_BYPASS_EN defined: if regWriteW=1 and wa3W==RAx (RAx≠15) in the same cycle, the read returns resultW (write-through); hazard unit needs no extra W→D stall.
- Undefined: same-cycle read returns the pre-write value; hazard unit must stall one cycle for that case.

## Structure
- Shared package arm_pkg: immSrc encodings (IMM_8, IMM_12, IMM_BR), R15 index constant, instruction field bit positions.
- One sub-module: regfile (15 entries, two async read ports, one sync write port, async reset, optional bypass); R15 substitution and extension stay in decode_stage.

## Test plan
- Reset: assert rst mid-run → all outputs 0, validE=0 immediately; regfile reads return 0 after release.
- Write/read: write R3=32'hDEADBEEF, next cycle instrD[19:16]=3 → rd1E=32'hDEADBEEF one edge later.
- R15: regSrcD[0]=1, pcPlus4D=32'h100 → rd1E=32'h104; write to index 15 leaves read still PC+8.
- Immediates: instrD[23:0]=24'hFFFFFE, immSrcD=10 → extImmE=32'hFFFFFFF8; instrD[11:0]=12'hABC, immSrcD=01 → 32'h00000ABC.
- Stall/flush: pipeEnable=0 holds outputs two cycles; flushE=1 with pipeEnable=0 → outputs 0, validE=0.
- Bypass: same-cycle write R5=7 and read R5 → rd1E=7 with DECODE_WB_BYPASS_EN, old value without.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core pipeline stages.
// Immediate encodings, R15 index, instruction field positions, D->E bundle.
package arm_pkg;

    localparam logic [1:0] IMM_8    = 2'b00;
    localparam logic [1:0] IMM_12   = 2'b01;
    localparam logic [1:0] IMM_BR   = 2'b10;
    localparam logic [1:0] IMM_ZERO = 2'b11;

    localparam logic [3:0] R15 = 4'hF;

    localparam int RN_HI    = 19;
    localparam int RN_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 12;
    localparam int RM_HI    = 3;
    localparam int RM_LO    = 0;
    localparam int IMM8_HI  = 7;
    localparam int IMM12_HI = 11;
    localparam int IMM24_HI = 23;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] ext_imm;
        logic [3:0]  wa3;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic        valid;
    } de_t;

endpackage

// File: rtl/decode_stage_regfile.sv
// 15-entry register file (R0-R14), two async reads, one sync write.
// Ports: i_clk, i_rst, i_ra1/i_ra2 -> o_rd1/o_rd2, i_we/i_wa/i_wd write.
// Macro DECODE_WB_BYPASS_EN: same-cycle write data forwarded to reads.
module decode_stage_regfile
    import arm_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_ra1,
    input  logic [3:0]  i_ra2,
    input  logic        i_we,
    input  logic [3:0]  i_wa,
    input  logic [31:0] i_wd,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);

    logic [31:0] r_regs [0:14];

    // Writes to index 15 are dropped: PC redirect is owned by fetch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 15; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_wa != R15)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // Index 15 reads 0 here; decode_stage substitutes PC+8.
    always_comb begin
        o_rd1 = '0;
        o_rd2 = '0;
        if (i_ra1 != R15) o_rd1 = r_regs[i_ra1];
        if (i_ra2 != R15) o_rd2 = r_regs[i_ra2];
`ifdef DECODE_WB_BYPASS_EN
        if (i_we && (i_wa == i_ra1) && (i_ra1 != R15)) o_rd1 = i_wd;
        if (i_we && (i_wa == i_ra2) && (i_ra2 != R15)) o_rd2 = i_wd;
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// ARM decode stage: register read (R15 = PC+8), immediate extend, D->E reg.
// Ports: clock, rst, instrD, pcPlus4D, regSrcD, immSrcD, W write-back
// (regWriteW, wa3W, resultW), pipeEnable, flushE; outputs *E and validE.
// Macro DECODE_WB_BYPASS_EN (in regfile): same-cycle W->D write-through.
module decode_stage
    import arm_pkg::*;
(
    input  logic        clock,
    input  logic        rst,
    input  logic [31:0] instrD,
    input  logic [31:0] pcPlus4D,
    input  logic [1:0]  regSrcD,
    input  logic [1:0]  immSrcD,
    input  logic        regWriteW,
    input  logic [3:0]  wa3W,
    input  logic [31:0] resultW,
    input  logic        pipeEnable,
    input  logic        flushE,
    output logic [31:0] rd1E,
    output logic [31:0] rd2E,
    output logic [31:0] extImmE,
    output logic [3:0]  wa3E,
    output logic [3:0]  ra1E,
    output logic [3:0]  ra2E,
    output logic        validE
);

    logic [3:0]  w_ra1;
    logic [3:0]  w_ra2;
    logic [31:0] w_rf_rd1;
    logic [31:0] w_rf_rd2;
    logic [31:0] w_pc8;
    logic [31:0] w_ext;
    de_t         w_de;
    de_t         r_de;
    logic        w_unused;

    assign w_unused = &{1'b0, instrD[31:24]};

    assign w_ra1 = regSrcD[0] ? R15 : instrD[RN_HI:RN_LO];
    assign w_ra2 = regSrcD[1] ? instrD[RD_HI:RD_LO]
                              : instrD[RM_HI:RM_LO];
    assign w_pc8 = pcPlus4D + 32'd4;

    decode_stage_regfile u_regfile (
        .i_clk (clock),
        .i_rst (rst),
        .i_ra1 (w_ra1),
        .i_ra2 (w_ra2),
        .i_we  (regWriteW),
        .i_wa  (wa3W),
        .i_wd  (resultW),
        .o_rd1 (w_rf_rd1),
        .o_rd2 (w_rf_rd2)
    );

    always_comb begin
        w_ext = '0;
        unique case (immSrcD)
            IMM_8:    w_ext = {24'd0, instrD[IMM8_HI:0]};
            IMM_12:   w_ext = {20'd0, instrD[IMM12_HI:0]};
            IMM_BR:   w_ext = {{6{instrD[IMM24_HI]}},
                               instrD[IMM24_HI:0], 2'b00};
            IMM_ZERO: w_ext = '0;
            default:  w_ext = '0;
        endcase
    end

    always_comb begin
        w_de         = '0;
        w_de.rd1     = (w_ra1 == R15) ? w_pc8 : w_rf_rd1;
        w_de.rd2     = (w_ra2 == R15) ? w_pc8 : w_rf_rd2;
        w_de.ext_imm = w_ext;
        w_de.wa3     = instrD[RD_HI:RD_LO];
        w_de.ra1     = w_ra1;
        w_de.ra2     = w_ra2;
        w_de.valid   = 1'b1;
    end

    // Flush has priority over load so a squashed op never reaches E.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_de <= '0;
        end else if (flushE) begin
            r_de <= '0;
        end else if (pipeEnable) begin
            r_de <= w_de;
        end
    end

    assign rd1E    = r_de.rd1;
    assign rd2E    = r_de.rd2;
    assign extImmE = r_de.ext_imm;
    assign wa3E    = r_de.wa3;
    assign ra1E    = r_de.ra1;
    assign ra2E    = r_de.ra2;
    assign validE  = r_de.valid;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage using a reference model and
// a scoreboard queue of expected D->E register contents.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instrD = '0;
    logic [31:0] pcPlus4D = '0;
    logic [1:0]  regSrcD = '0;
    logic [1:0]  immSrcD = '0;
    logic        regWriteW = 1'b0;
    logic [3:0]  wa3W = '0;
    logic [31:0] resultW = '0;
    logic        pipeEnable = 1'b0;
    logic        flushE = 1'b0;
    logic [31:0] rd1E;
    logic [31:0] rd2E;
    logic [31:0] extImmE;
    logic [3:0]  wa3E;
    logic [3:0]  ra1E;
    logic [3:0]  ra2E;
    logic        validE;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [3:0]  wa3;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic        valid;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        m_cur;
    logic [31:0] m_rf [0:14];
    int          n_checks = 0;
    int          n_errors = 0;

    decode_stage dut (
        .clock      (clock),
        .rst        (rst),
        .instrD     (instrD),
        .pcPlus4D   (pcPlus4D),
        .regSrcD    (regSrcD),
        .immSrcD    (immSrcD),
        .regWriteW  (regWriteW),
        .wa3W       (wa3W),
        .resultW    (resultW),
        .pipeEnable (pipeEnable),
        .flushE     (flushE),
        .rd1E       (rd1E),
        .rd2E       (rd2E),
        .extImmE    (extImmE),
        .wa3E       (wa3E),
        .ra1E       (ra1E),
        .ra2E       (ra2E),
        .validE     (validE)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input exp_t e);
        chk({tag, ".rd1"}, rd1E, e.rd1);
        chk({tag, ".rd2"}, rd2E, e.rd2);
        chk({tag, ".imm"}, extImmE, e.imm);
        chk({tag, ".wa3"}, {28'd0, wa3E}, {28'd0, e.wa3});
        chk({tag, ".ra1"}, {28'd0, ra1E}, {28'd0, e.ra1});
        chk({tag, ".ra2"}, {28'd0, ra2E}, {28'd0, e.ra2});
        chk({tag, ".val"}, {31'd0, validE}, {31'd0, e.valid});
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] a,
                                           input logic [31:0] pc4,
                                           input logic we,
                                           input logic [3:0] wa,
                                           input logic [31:0] wd);
        if (a == 4'hF) return pc4 + 32'd4;
`ifdef DECODE_WB_BYPASS_EN
        if (we && wa == a) return wd;
`endif
        return m_rf[a];
    endfunction

    task automatic step(input string tag, input logic [31:0] ins,
                        input logic [31:0] pc4, input logic [1:0] rs,
                        input logic [1:0] is, input logic we,
                        input logic [3:0] wa, input logic [31:0] wd,
                        input logic pe, input logic fl);
        exp_t n;
        exp_t e;
        @(negedge clock);
        instrD = ins; pcPlus4D = pc4; regSrcD = rs; immSrcD = is;
        regWriteW = we; wa3W = wa; resultW = wd;
        pipeEnable = pe; flushE = fl;
        n.ra1 = rs[0] ? 4'hF : ins[19:16];
        n.ra2 = rs[1] ? ins[15:12] : ins[3:0];
        n.rd1 = m_read(n.ra1, pc4, we, wa, wd);
        n.rd2 = m_read(n.ra2, pc4, we, wa, wd);
        case (is)
            2'b00: n.imm = {24'd0, ins[7:0]};
            2'b01: n.imm = {20'd0, ins[11:0]};
            2'b10: n.imm = {{6{ins[23]}}, ins[23:0], 2'b00};
            default: n.imm = 32'd0;
        endcase
        n.wa3 = ins[15:12];
        n.valid = 1'b1;
        if (fl) n = '0;
        else if (!pe) n = m_cur;
        m_cur = n;
        sb_q.push_back(n);
        @(posedge clock);
        #1;
        if (we && wa != 4'hF) m_rf[wa] = wd;
        if (sb_q.size() == 0) begin
            chk({tag, ".q"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk_outs(tag, e);
        end
    endtask

    initial begin
        exp_t z;
        z = '0;
        m_cur = '0;
        for (int i = 0; i < 15; i++) m_rf[i] = '0;
        #12;
        chk_outs("reset", z);
        @(negedge clock);
        rst = 1'b0;

        step("wr_r3", 32'h0000_0000, 32'h0, 2'b00, 2'b00,
             1'b1, 4'd3, 32'hDEADBEEF, 1'b1, 1'b0);
        step("rd_r3", 32'h0003_3003, 32'h0, 2'b00, 2'b00,
             1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
        step("r15", 32'h0000_2000, 32'h100, 2'b01, 2'b00,
             1'b1, 4'd15, 32'h1234_5678, 1'b1, 1'b0);
        step("r15_after", 32'h0000_F00F, 32'h100, 2'b11, 2'b00,
             1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
        step("r15_wrap", 32'h0, 32'hFFFF_FFFE, 2'b01, 2'b00,
             1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
        step("imm_br", 32'h00FF_FFFE, 32'h0, 2'b00, 2'b10,
             1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
        step("imm_12", 32'h0000_0ABC, 32'h0, 2'b00, 2'b01,
             1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
        step("imm_8", 32'h0000_0ABC, 32'h0, 2'b00, 2'b00,
             1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
        step("imm_z", 32'h00FF_FFFF, 32'h0, 2'b00, 2'b11,
             1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
        step("stall1", 32'h0012_3456, 32'h40, 2'b10, 2'b01,
             1'b1, 4'd1, 32'h11, 1'b0, 1'b0);
        step("stall2", 32'h0065_4321, 32'h80, 2'b01, 2'b10,
             1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
        step("rd_r1", 32'h0001_1001, 32'h0, 2'b00, 2'b00,
             1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
        step("flush", 32'h0003_3003, 32'h0, 2'b00, 2'b00,
             1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
        step("flush_pe", 32'h0003_3003, 32'h0, 2'b00, 2'b00,
             1'b0, 4'd0, 32'h0, 1'b1, 1'b1);
        step("byp_r5", 32'h0005_5005, 32'h0, 2'b00, 2'b00,
             1'b1, 4'd5, 32'd7, 1'b1, 1'b0);
        step("rd_r5", 32'h0005_5005, 32'h0, 2'b00, 2'b00,
             1'b0, 4'd0, 32'h0, 1'b1, 1'b0);

        for (int k = 0; k < 40; k++) begin
            step("rand", $urandom, $urandom, 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
        end

        step("pre_rst", 32'h0003_3003, 32'h0, 2'b00, 2'b00,
             1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
        pipeEnable = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_outs("async_rst", z);
        for (int i = 0; i < 15; i++) m_rf[i] = '0;
        m_cur = '0;
        @(negedge clock);
        chk_outs("rst_hold", z);
        rst = 1'b0;
        step("post_rst", 32'h0003_3003, 32'h0, 2'b00, 2'b00,
             1'b0, 4'd0, 32'h0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
